// File: rtl/ram_pkg.sv
// Shared types and the byte-lane merge used by the simple-dual-port RAM.
// Widths are bounded by MAX_DATA_W / MAX_BYTES; callers zero-extend and truncate.
package ram_pkg;

   typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} ram_clear_state_t;

   localparam int MAX_DATA_W = 256;
   localparam int MAX_BYTES  = 32;

   // Lane b of the result comes from new_word when be[b] is set, else from old_word.
   function automatic logic [MAX_DATA_W-1:0] byte_merge(
      input logic [MAX_DATA_W-1:0] old_word,
      input logic [MAX_DATA_W-1:0] new_word,
      input logic [MAX_BYTES-1:0]  be,
      input int                    num_bytes,
      input int                    byte_width
   );
      logic [MAX_DATA_W-1:0] res;
      int                    lane;
      res = old_word;
      for (int i = 0; i < MAX_DATA_W; i++) begin
         lane = i / byte_width;
         if (lane < num_bytes && be[lane[4:0]]) begin
            res[i] = new_word[i];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-data delay line: DEPTH stages of data plus valid.
// A stage only reloads its data when the incoming valid is set, so the output holds between reads.
module ram_rd_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_vld,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_vld,
   output logic [DATA_WIDTH-1:0] out_data
);

   if (DEPTH < 1) begin : g_chk_depth
      $fatal(1, "ram_rd_pipe: DEPTH must be at least 1");
   end

   logic [DEPTH-1:0]      vld_p;
   logic [DATA_WIDTH-1:0] data_p [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_p[i] <= '0;
         end
      end else begin
         vld_p[0] <= in_vld;
         if (in_vld) begin
            data_p[0] <= in_data;
         end
         for (int i = 1; i < DEPTH; i++) begin
            vld_p[i] <= vld_p[i-1];
            if (vld_p[i-1]) begin
               data_p[i] <= data_p[i-1];
            end
         end
      end
   end

   assign out_vld  = vld_p[DEPTH-1];
   assign out_data = data_p[DEPTH-1];

endmodule

// File: rtl/ram_sdp_be_pipe.sv
// Simple-dual-port RAM with byte-lane writes, selectable read-during-write,
// post-reset clear sequence and a 1..4 cycle read pipeline with valid.
module ram_sdp_be_pipe
   import ram_pkg::*;
#(
   parameter int                   DATA_WIDTH     = 32,
   parameter int                   BYTE_WIDTH     = 8,
   parameter int                   ADDR_WIDTH     = 10,
   parameter int                   RD_LATENCY     = 2,
   parameter int                   WRITE_FIRST    = 1,
   parameter int                   CLEAR_ON_RESET = 1,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0,
   localparam int                  NUM_BYTES      = DATA_WIDTH / BYTE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  ready,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [NUM_BYTES-1:0]  wr_be,
   input  logic [DATA_WIDTH-1:0] wr_data
);

   localparam int                    DEPTH      = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] CNT_PENULT = ADDR_WIDTH'(DEPTH - 2);

   if (BYTE_WIDTH < 1 || (DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_chk_bytes
      $fatal(1, "ram_sdp_be_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
   end
   if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_chk_lat
      $fatal(1, "ram_sdp_be_pipe: RD_LATENCY must be within 1..4");
   end
   if (ADDR_WIDTH < 1 || DATA_WIDTH > MAX_DATA_W || NUM_BYTES > MAX_BYTES) begin : g_chk_size
      $fatal(1, "ram_sdp_be_pipe: unsupported ADDR_WIDTH/DATA_WIDTH");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   ram_clear_state_t      state;
   ram_clear_state_t      state_nxt;
   logic [ADDR_WIDTH-1:0] clr_cnt;
   logic                  clr_last;
   logic                  clr_we;

   logic                  rd_acc;
   logic                  wr_acc;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [NUM_BYTES-1:0]  mem_wbe;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [NUM_BYTES-1:0]  byp_sel;

   logic                  vld_p0;
   logic [DATA_WIDTH-1:0] rdata_p0;
   logic [DATA_WIDTH-1:0] byp_data_p0;
   logic [NUM_BYTES-1:0]  byp_sel_p0;
   logic [DATA_WIDTH-1:0] mrg_p0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (state == CLEAR && clr_last) begin
         state_nxt = RUN;
      end
   end

   always_comb begin
      ready  = (state == RUN);
      clr_we = (state == CLEAR);
   end

   // clr_last marks that clr_cnt already points at the final word, so the counter stops there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_cnt  <= '0;
         clr_last <= 1'b0;
      end else if (clr_we && !clr_last) begin
         clr_cnt  <= clr_cnt + ADDR_WIDTH'(1);
         clr_last <= (clr_cnt == CNT_PENULT);
      end
   end

   assign rd_acc = ready & rd_en;
   assign wr_acc = ready & wr_en;

   always_comb begin
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
      mem_wbe   = '0;
      if (clr_we) begin
         mem_waddr = clr_cnt;
         mem_wdata = CLEAR_VALUE;
         mem_wbe   = '1;
      end else if (wr_acc) begin
         mem_wbe = wr_be;
      end
   end

   always_ff @(posedge clk) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
         if (mem_wbe[b]) begin
            mem[mem_waddr][b*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   // Same-address collision: remember which lanes the concurrent write touched.
   assign byp_sel = (WRITE_FIRST != 0 && wr_acc && wr_addr == rd_addr) ? wr_be : '0;

   // Stage p0: RAM output register and bypass capture, loaded only on an accepted read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0      <= 1'b0;
         rdata_p0    <= '0;
         byp_data_p0 <= '0;
         byp_sel_p0  <= '0;
      end else begin
         vld_p0 <= rd_acc;
         if (rd_acc) begin
            rdata_p0    <= mem[rd_addr];
            byp_data_p0 <= wr_data;
            byp_sel_p0  <= byp_sel;
         end
      end
   end

   assign mrg_p0 = DATA_WIDTH'(byte_merge(MAX_DATA_W'(rdata_p0), MAX_DATA_W'(byp_data_p0),
                                          MAX_BYTES'(byp_sel_p0), NUM_BYTES, BYTE_WIDTH));

   // Stages p1..: remaining latency after the merge.
   if (RD_LATENCY == 1) begin : g_lat1
      assign rd_valid = vld_p0;
      assign rd_data  = mrg_p0;
   end else begin : g_latn
      ram_rd_pipe #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (RD_LATENCY - 1)
      ) u_rd_pipe (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_vld   (vld_p0),
         .in_data  (mrg_p0),
         .out_vld  (rd_valid),
         .out_data (rd_data)
      );
   end

endmodule
